// File: rtl/div_tick_ctrl.sv
// Programmable divided-clock controller: 50% duty div_out with a tick on every rise,
// start/stop sequencing, finite bursts and a valid/ready config port applied at period boundaries.
module div_tick_ctrl #(
  parameter int CNT_W        = 16,
  parameter int BURST_W      = 16,
  parameter int DEFAULT_HALF = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               div_out,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] period_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Config handshake: a transfer happens on any edge where cfg_valid && cfg_ready.
  // cfg_ready is low only while a captured config waits for the next boundary.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   q_q, q_d;
  logic               div_q, div_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] period_q, period_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               pend_v_q, pend_v_d;
  logic [CNT_W-1:0]   pend_half_q, pend_half_d;
  logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
  logic               stop_q, stop_d;

  logic               cfg_xfer;
  logic [CNT_W-1:0]   h_last;
  logic               last;
  logic               end_run;
  logic [BURST_W-1:0] period_inc;

  assign cfg_ready  = ~pend_v_q;
  assign cfg_xfer   = cfg_valid & cfg_ready;
  // A programmed half-period of zero behaves as one.
  assign h_last     = (half_q == '0) ? '0 : half_q - CNT_W'(1);
  assign last       = (q_q == h_last);
  assign period_inc = period_q + BURST_W'(1);

  always_comb begin
    state_d      = state_q;
    q_d          = q_q;
    div_d        = div_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    period_d     = period_q;
    half_d       = half_q;
    burst_d      = burst_q;
    pend_v_d     = pend_v_q;
    pend_half_d  = pend_half_q;
    pend_burst_d = pend_burst_q;
    stop_d       = stop_q;
    end_run      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_xfer) begin
          half_d  = cfg_half;
          burst_d = cfg_burst;
        end
        if (start && !stop) begin
          state_d  = RUN;
          q_d      = '0;
          div_d    = 1'b0;
          period_d = '0;
          stop_d   = 1'b0;
        end
      end
      RUN: begin
        if (stop) stop_d = 1'b1;
        if (cfg_xfer) begin
          pend_v_d     = 1'b1;
          pend_half_d  = cfg_half;
          pend_burst_d = cfg_burst;
        end
        if (stop_q && !div_q) begin
          end_run = 1'b1;
        end else if (last) begin
          q_d   = '0;
          div_d = ~div_q;
          if (!div_q) begin
            tick_d = 1'b1;
          end else if (pend_v_q) begin
            // Boundary that installs a pending config restarts the period count.
            half_d   = pend_half_q;
            burst_d  = pend_burst_q;
            pend_v_d = 1'b0;
            period_d = '0;
            end_run  = stop_q;
          end else begin
            period_d = period_inc;
            end_run  = stop_q || ((burst_q != '0) && (period_inc == burst_q));
          end
        end else begin
          q_d = q_q + CNT_W'(1);
        end

        if (end_run) begin
          state_d = IDLE;
          q_d     = '0;
          div_d   = 1'b0;
          tick_d  = 1'b0;
          done_d  = 1'b1;
          stop_d  = 1'b0;
          if (pend_v_q) begin
            half_d   = pend_half_q;
            burst_d  = pend_burst_q;
            pend_v_d = 1'b0;
            period_d = '0;
          end else if (cfg_xfer) begin
            half_d   = cfg_half;
            burst_d  = cfg_burst;
            pend_v_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      q_q          <= '0;
      div_q        <= 1'b0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      period_q     <= '0;
      half_q       <= CNT_W'(DEFAULT_HALF);
      burst_q      <= '0;
      pend_v_q     <= 1'b0;
      pend_half_q  <= '0;
      pend_burst_q <= '0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_q          <= q_d;
      div_q        <= div_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      period_q     <= period_d;
      half_q       <= half_d;
      burst_q      <= burst_d;
      pend_v_q     <= pend_v_d;
      pend_half_q  <= pend_half_d;
      pend_burst_q <= pend_burst_d;
      stop_q       <= stop_d;
    end
  end

  assign div_out    = div_q;
  assign tick       = tick_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
  assign period_cnt = period_q;

endmodule

// File: tb/tb_div_tick_ctrl.sv
// Directed bench for div_tick_ctrl; cycle k means the sample taken 1ns after start edge E0+k.
module tb_div_tick_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_half = '0;
  logic [15:0] cfg_burst = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        div_out, tick, busy, done;
  logic [15:0] period_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_tick_ctrl #(.CNT_W(16), .BURST_W(16), .DEFAULT_HALF(16)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .div_out(div_out), .tick(tick), .busy(busy), .done(done), .period_cnt(period_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] h, input logic [15:0] b);
    cfg_valid = 1'b1; cfg_half = h; cfg_burst = b;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_run(input string name);
    bit seen = 0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_done_timeout got no done want done within 40", name); end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++;
    if ({div_out, tick, busy, done, cfg_ready, period_cnt} !== {5'b00001, 16'd0}) begin
      errors++;
      $display("FAIL reset_vals got %b want %b", {div_out, tick, busy, done, cfg_ready, period_cnt}, {5'b00001, 16'd0});
    end
    start_run();
    for (int k = 1; k <= 16; k++) step();
    checks++;
    if ({tick, div_out} !== 2'b11) begin errors++; $display("FAIL default_half_rise got %b want 11", {tick, div_out}); end
    end_run("reset");
  endtask

  task automatic test_free_run();
    int tcount = 0;
    cfg_write(16'd3, 16'd0);
    start_run();
    for (int k = 1; k <= 18; k++) begin
      step();
      checks++;
      if (div_out !== 1'(((k / 3) % 2)) || tick !== (k % 6 == 3) || period_cnt !== 16'(k / 6)) begin
        errors++;
        $display("FAIL free_run_k%0d got div=%b tick=%b per=%0d want div=%0d tick=%0d per=%0d",
                 k, div_out, tick, period_cnt, (k / 3) % 2, (k % 6 == 3), k / 6);
      end
      if (tick === 1'b1) tcount++;
    end
    checks++;
    if (tcount != 3) begin errors++; $display("FAIL free_run_ticks got %0d want 3", tcount); end
    end_run("free_run");
  endtask

  task automatic test_burst();
    int tcount = 0;
    cfg_write(16'd2, 16'd4);
    start_run();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (tick === 1'b1) tcount++;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL burst_early_k%0d got done=%b busy=%b want 0 1", k, done, busy); end
    end
    step();
    checks++;
    if ({done, busy, div_out, tick} !== 4'b1000 || period_cnt !== 16'd4) begin
      errors++;
      $display("FAIL burst_end got dbdt=%b per=%0d want 1000 per=4", {done, busy, div_out, tick}, period_cnt);
    end
    checks++;
    if (tcount != 4) begin errors++; $display("FAIL burst_ticks got %0d want 4", tcount); end
    step();
    checks++;
    if ({done, div_out, busy} !== 3'b000) begin errors++; $display("FAIL burst_after got %b want 000", {done, div_out, busy}); end
  endtask

  task automatic test_cfg_in_run();
    cfg_write(16'd4, 16'd0);
    start_run();
    for (int k = 1; k <= 4; k++) step();
    cfg_write(16'd1, 16'd0);  // transfer at E5
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_pend_ready got %b want 0", cfg_ready); end
    step(); step();           // E7
    checks++;
    if (cfg_ready !== 1'b0 || period_cnt !== 16'd0) begin
      errors++; $display("FAIL cfg_pend_hold got rdy=%b per=%0d want 0 0", cfg_ready, period_cnt);
    end
    step();                   // E8 boundary
    checks++;
    if (cfg_ready !== 1'b1 || period_cnt !== 16'd0 || div_out !== 1'b0) begin
      errors++; $display("FAIL cfg_apply got rdy=%b per=%0d div=%b want 1 0 0", cfg_ready, period_cnt, div_out);
    end
    step();                   // E9
    checks++;
    if ({tick, div_out} !== 2'b11) begin errors++; $display("FAIL cfg_new_rise got %b want 11", {tick, div_out}); end
    step();                   // E10
    checks++;
    if (div_out !== 1'b0 || period_cnt !== 16'd1) begin
      errors++; $display("FAIL cfg_new_fall got div=%b per=%0d want 0 1", div_out, period_cnt);
    end
    end_run("cfg_run");
  endtask

  task automatic test_stop();
    bit any_tick = 0;
    cfg_write(16'd5, 16'd0);
    start_run();
    step();                   // E1
    stop = 1'b1; step(); stop = 1'b0;  // latched at E2
    if (tick === 1'b1) any_tick = 1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stop_low_wait got done=%b busy=%b want 0 1", done, busy); end
    step();                   // E3
    if (tick === 1'b1) any_tick = 1;
    checks++;
    if ({done, busy, div_out} !== 3'b100 || any_tick) begin
      errors++; $display("FAIL stop_low got dbd=%b tick_seen=%0d want 100 0", {done, busy, div_out}, any_tick);
    end
    step();
    start_run();
    for (int k = 1; k <= 6; k++) step();
    stop = 1'b1; step(); stop = 1'b0;  // latched at E7, div high
    checks++;
    if (div_out !== 1'b1) begin errors++; $display("FAIL stop_high_div got %b want 1", div_out); end
    step(); step();           // E9
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stop_high_wait got done=%b busy=%b want 0 1", done, busy); end
    step();                   // E10 boundary
    checks++;
    if ({done, busy, div_out} !== 3'b100 || period_cnt !== 16'd1) begin
      errors++; $display("FAIL stop_high got dbd=%b per=%0d want 100 1", {done, busy, div_out}, period_cnt);
    end
    step();
  endtask

  task automatic test_half_zero_reset();
    cfg_write(16'd0, 16'd0);
    start_run();
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (div_out !== 1'(k % 2) || tick !== 1'(k % 2) || period_cnt !== 16'(k / 2)) begin
        errors++;
        $display("FAIL h0_k%0d got div=%b tick=%b per=%0d want %0d %0d %0d", k, div_out, tick, period_cnt, k % 2, k % 2, k / 2);
      end
    end
    reset = 1'b1; step(); reset = 1'b0;
    checks++;
    if ({div_out, tick, busy, done, cfg_ready, period_cnt} !== {5'b00001, 16'd0}) begin
      errors++;
      $display("FAIL midrun_reset got %b want %b", {div_out, tick, busy, done, cfg_ready, period_cnt}, {5'b00001, 16'd0});
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_after got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_start_stop_and_boundary_cfg();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_stop got busy=%b done=%b want 0 0", busy, done); end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_stop_after got busy=%b done=%b want 0 0", busy, done); end
    cfg_write(16'd2, 16'd0);
    start_run();
    for (int k = 1; k <= 3; k++) step();
    cfg_write(16'd3, 16'd0);  // transfer coincides with boundary E4
    checks++;
    if (period_cnt !== 16'd1 || cfg_ready !== 1'b0) begin
      errors++; $display("FAIL bcfg_e4 got per=%0d rdy=%b want 1 0", period_cnt, cfg_ready);
    end
    for (int k = 5; k <= 8; k++) step();
    checks++;
    if (period_cnt !== 16'd0 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL bcfg_e8 got per=%0d rdy=%b want 0 1", period_cnt, cfg_ready);
    end
    step(); step();           // E10
    checks++;
    if ({tick, div_out} !== 2'b00) begin errors++; $display("FAIL bcfg_e10 got %b want 00", {tick, div_out}); end
    step();                   // E11
    checks++;
    if ({tick, div_out} !== 2'b11) begin errors++; $display("FAIL bcfg_e11 got %b want 11", {tick, div_out}); end
    end_run("bcfg");
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_burst();
    test_cfg_in_run();
    test_stop();
    test_half_zero_reset();
    test_start_stop_and_boundary_cfg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
